tiny_proc_core: RTL and testbench
=================================

Name: tiny_proc_core

Overview:
- Minimal 8-bit processor core: 4-entry × 16-bit instruction ROM, 4 × 8-bit register file, 8-bit ALU, 4-state sequencer.
- Fetches, decodes and executes LOAD-immediate and register-register ALU instructions.
- Standalone block; exposes PC, IR, ALU result, halt status and a debug register read port for system-level checking.

Parameters:
- ROM0, 16'h8005, instruction word at address 0 (LOAD R0,5)
- ROM1, 16'h8103, instruction word at address 1 (LOAD R1,3)
- ROM2, 16'h0201, instruction word at address 2 (ADD R2,R0,R1)
- ROM3, 16'h1301, instruction word at address 3 (SUB R3,R0,R1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run enable; low freezes all state
- dbg_addr  input  2  debug register-file read address
- dbg_data  output  8  combinational contents of R[dbg_addr]
- pc  output  2  current program counter
- ir  output  16  current instruction register
- alu_out  output  8  registered ALU result
- alu_zero  output  1  high when alu_out == 0
- halted  output  1  high once the final instruction has retired

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=0, ir=0, alu_out=0, alu_zero=1, halted=0
  - R0..R3=0
  - internal operand latches A=B=0
  - state=FETCH
- Sequencer: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH. Each state lasts one clock with en=1, so each instruction takes 4 cycles.
- en=0 holds state and all registers, in every state.
- FETCH: ir <= ROM[pc].
- DECODE: A <= R[ir[5:4]], B <= R[ir[1:0]].
- EXECUTE: alu_out <= ALU(op, A, B), where op = ir[14:12]. Updated only when ir[15]=0.
- WRITEBACK:
  - ir[15]=0 (ALU class): R[ir[9:8]] <= alu_out.
  - ir[15:12]=4'b1000 (LOAD): R[ir[9:8]] <= ir[7:0].
  - ir[15:12]=1001..1111: NOP, no register write.
  - Then pc <= pc+1, or, if pc==3, set halted=1 and hold pc at 3.
- Instruction field usage:
  - ir[11:10], ir[7:6], ir[3:2] are ignored for ALU ops.
  - ir[11:10] is ignored for LOAD.
- ALU ops (8-bit, result modulo 256, no carry out):
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 A<<1
  - 111 A>>1 (logical)
- Register read/write ordering: a register written in WRITEBACK is visible to the next instruction's DECODE. No forwarding is needed, because reads and writes never occur in the same cycle.
- halted=1: sequencer parks in FETCH and makes no further register writes. Only reset clears halted.
- Reset asserted mid-instruction: immediate return to reset values. The partially executed instruction has no effect.
- dbg_data is combinational and unaffected by en.

Optional Feature:
- Macro TINY_PROC_PC_WRAP_EN.
- Defined: after WRITEBACK at pc==3, pc wraps to 0 and execution continues forever; halted is tied 0.
- Undefined: halt behaviour as above.

Decomposition:
- Package tiny_proc_pkg holds:
  - ALU op constants (OP_ADD..OP_SHR)
  - LOAD class constant 4'b1000
  - sequencer state enum (FETCH, DECODE, EXECUTE, WRITEBACK)
  - field bit positions (dest [9:8], srcA [5:4], srcB [1:0], imm [7:0])
- One natural sub-module: tiny_proc_alu (purely combinational: op, A, B → result).
- Register file and ROM stay inline in the core.

Test Plan:
- Reset: hold rst_n=0 with clk running → pc=0, ir=0, alu_out=0, halted=0, all dbg_data reads 0.
- Default program, en=1, 16 cycles:
  - R0=5, R1=3, R2=8, R3=2
  - ir sequence 8005, 8103, 0201, 1301
  - halted=1 after cycle 16; pc stays 3 thereafter.
- Underflow: ROM0=8003, ROM1=8105, ROM2=1201 → R2=0xFE; ADD of 0xFF+0x01 yields 0x00 with alu_zero=1.
- Stall: drop en for 5 cycles mid-EXECUTE → pc, ir and registers unchanged; final results identical to the default run, only delayed 5 cycles.
- Reset mid-operation: assert rst_n low during WRITEBACK of instruction 2 → R2 stays 0; after release, execution restarts at pc=0.
- With TINY_PROC_PC_WRAP_EN defined: after 16 cycles pc=0, halted=0; after 32 cycles register values are unchanged from the first pass.

Source files
------------

// File: rtl/tiny_proc_pkg.sv
// Shared constants, sequencer states and instruction-field helpers for tiny_proc_core.
package tiny_proc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam logic [3:0] CLASS_LOAD = 4'b1000;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_e;

  localparam int DEST_LSB = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;
  localparam int IMM_LSB  = 0;

  function automatic logic [1:0] f_dest(input logic [15:0] instr);
    return instr[DEST_LSB +: 2];
  endfunction

  function automatic logic [1:0] f_srca(input logic [15:0] instr);
    return instr[SRCA_LSB +: 2];
  endfunction

  function automatic logic [1:0] f_srcb(input logic [15:0] instr);
    return instr[SRCB_LSB +: 2];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] instr);
    return instr[IMM_LSB +: 8];
  endfunction

endpackage

// File: rtl/tiny_proc_alu.sv
// Combinational 8-bit ALU; results wrap modulo 256 with no carry out.
module tiny_proc_alu
  import tiny_proc_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  // Operation select
  always_comb begin
    result = 8'd0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = {a[6:0], 1'b0};
      OP_SHR:  result = {1'b0, a[7:1]};
      default: result = 8'd0;
    endcase
  end

endmodule

// File: rtl/tiny_proc_core.sv
// Four-state 8-bit processor core running a 4-word ROM program.
// Define TINY_PROC_PC_WRAP_EN to loop the program forever instead of halting.
module tiny_proc_core
  import tiny_proc_pkg::*;
#(
  parameter logic [15:0] ROM0 = 16'h8005,
  parameter logic [15:0] ROM1 = 16'h8103,
  parameter logic [15:0] ROM2 = 16'h0201,
  parameter logic [15:0] ROM3 = 16'h1301
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [1:0]  pc,
  output logic [15:0] ir,
  output logic [7:0]  alu_out,
  output logic        alu_zero,
  output logic        halted
);

  state_e      state_r;
  state_e      state_s;
  logic [1:0]  pc_r;
  logic [15:0] ir_r;
  logic [7:0]  alu_out_r;
  logic        alu_zero_r;
  logic        halted_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [7:0]  regs_r [4];
  logic [15:0] rom_word_s;
  logic [7:0]  alu_res_s;
  logic        wr_en_s;
  logic [7:0]  wr_data_s;

  tiny_proc_alu u_alu (
    .op     (ir_r[14:12]),
    .a      (a_r),
    .b      (b_r),
    .result (alu_res_s)
  );

  // Instruction ROM
  always_comb begin
    rom_word_s = 16'h0000;
    case (pc_r)
      2'd0:    rom_word_s = ROM0;
      2'd1:    rom_word_s = ROM1;
      2'd2:    rom_word_s = ROM2;
      2'd3:    rom_word_s = ROM3;
      default: rom_word_s = 16'h0000;
    endcase
  end

  // Writeback source: ALU class writes the latched result, LOAD writes the immediate
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = 8'd0;
    if (ir_r[15] == 1'b0) begin
      wr_en_s   = 1'b1;
      wr_data_s = alu_out_r;
    end else if (ir_r[15:12] == CLASS_LOAD) begin
      wr_en_s   = 1'b1;
      wr_data_s = f_imm(ir_r);
    end else begin
      wr_en_s   = 1'b0;
      wr_data_s = 8'd0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Sequencer next state; a halted core parks in FETCH
  always_comb begin
    state_s = state_r;
    if (en) begin
      case (state_r)
        FETCH:     state_s = halted_r ? FETCH : DECODE;
        DECODE:    state_s = EXECUTE;
        EXECUTE:   state_s = WRITEBACK;
        WRITEBACK: state_s = FETCH;
        default:   state_s = FETCH;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= 2'd0;
      ir_r       <= 16'h0000;
      alu_out_r  <= 8'd0;
      alu_zero_r <= 1'b1;
      halted_r   <= 1'b0;
      a_r        <= 8'd0;
      b_r        <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'd0;
      end
    end else if (en) begin
      case (state_r)
        FETCH: begin
          if (!halted_r) begin
            ir_r <= rom_word_s;
          end
        end
        DECODE: begin
          a_r <= regs_r[f_srca(ir_r)];
          b_r <= regs_r[f_srcb(ir_r)];
        end
        EXECUTE: begin
          if (ir_r[15] == 1'b0) begin
            alu_out_r  <= alu_res_s;
            alu_zero_r <= (alu_res_s == 8'd0);
          end
        end
        WRITEBACK: begin
          if (wr_en_s) begin
            regs_r[f_dest(ir_r)] <= wr_data_s;
          end
`ifdef TINY_PROC_PC_WRAP_EN
          pc_r <= pc_r + 2'd1;
`else
          if (pc_r == 2'd3) begin
            halted_r <= 1'b1;
          end else begin
            pc_r <= pc_r + 2'd1;
          end
`endif
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign dbg_data = regs_r[dbg_addr];
  assign pc       = pc_r;
  assign ir       = ir_r;
  assign alu_out  = alu_out_r;
  assign alu_zero = alu_zero_r;
  assign halted   = halted_r;

endmodule

// File: tb/tb_tiny_proc_core.sv
// Directed bench for tiny_proc_core: default program table, stall, mid-op reset, wrap-around arithmetic.
module tb_tiny_proc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  dbg_addr = 2'd0;

  logic [7:0]  dbg_data;
  logic [1:0]  pc;
  logic [15:0] ir;
  logic [7:0]  alu_out;
  logic        alu_zero;
  logic        halted;

  logic [7:0]  uf_dbg_data;
  logic [1:0]  uf_pc;
  logic [15:0] uf_ir;
  logic [7:0]  uf_alu_out;
  logic        uf_alu_zero;
  logic        uf_halted;

  logic [7:0]  zr_dbg_data;
  logic [1:0]  zr_pc;
  logic [15:0] zr_ir;
  logic [7:0]  zr_alu_out;
  logic        zr_alu_zero;
  logic        zr_halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  pc;
    logic [15:0] ir;
    logic [7:0]  alu;
    logic        zero;
    logic        halted;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  tiny_proc_core dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pc(pc), .ir(ir), .alu_out(alu_out), .alu_zero(alu_zero), .halted(halted)
  );

  // 3 - 5 underflows to FE
  tiny_proc_core #(.ROM0(16'h8003), .ROM1(16'h8105), .ROM2(16'h1201), .ROM3(16'h9000)) u_uf (
    .clk(clk), .rst_n(rst_n), .en(en), .dbg_addr(dbg_addr), .dbg_data(uf_dbg_data),
    .pc(uf_pc), .ir(uf_ir), .alu_out(uf_alu_out), .alu_zero(uf_alu_zero), .halted(uf_halted)
  );

  // FF + 01 wraps to 00, then R3 = FF << 1
  tiny_proc_core #(.ROM0(16'h80FF), .ROM1(16'h8101), .ROM2(16'h0201), .ROM3(16'h6300)) u_zr (
    .clk(clk), .rst_n(rst_n), .en(en), .dbg_addr(dbg_addr), .dbg_data(zr_dbg_data),
    .pc(zr_pc), .ir(zr_ir), .alu_out(zr_alu_out), .alu_zero(zr_alu_zero), .halted(zr_halted)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // inst: 0 = default core, 1 = underflow core, 2 = zero core
  task automatic chk_reg(input string name, input int inst, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    case (inst)
      1:       chk(name, {24'd0, uf_dbg_data}, {24'd0, exp});
      2:       chk(name, {24'd0, zr_dbg_data}, {24'd0, exp});
      default: chk(name, {24'd0, dbg_data}, {24'd0, exp});
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{2'd0, 16'h8005, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{2'd0, 16'h8005, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{2'd0, 16'h8005, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 16'h8005, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{2'd1, 16'h8103, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{2'd1, 16'h8103, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{2'd1, 16'h8103, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{2'd2, 16'h8103, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{2'd2, 16'h0201, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{2'd2, 16'h0201, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{2'd2, 16'h0201, 8'h08, 1'b0, 1'b0};
    tbl[11] = '{2'd3, 16'h0201, 8'h08, 1'b0, 1'b0};
    tbl[12] = '{2'd3, 16'h1301, 8'h08, 1'b0, 1'b0};
    tbl[13] = '{2'd3, 16'h1301, 8'h08, 1'b0, 1'b0};
    tbl[14] = '{2'd3, 16'h1301, 8'h02, 1'b0, 1'b0};
`ifdef TINY_PROC_PC_WRAP_EN
    tbl[15] = '{2'd0, 16'h1301, 8'h02, 1'b0, 1'b0};
`else
    tbl[15] = '{2'd3, 16'h1301, 8'h02, 1'b0, 1'b1};
`endif

    // Reset state while held in reset with the clock running
    rst_n = 1'b0;
    en    = 1'b1;
    step(3);
    chk("rst_pc", {30'd0, pc}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_alu", {24'd0, alu_out}, 32'd0);
    chk("rst_zero", {31'd0, alu_zero}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      chk_reg($sformatf("rst_R%0d", r), 0, r[1:0], 8'h00);
    end

    // Default program, cycle-by-cycle table
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk($sformatf("pc_c%0d", i + 1), {30'd0, pc}, {30'd0, tbl[i].pc});
      chk($sformatf("ir_c%0d", i + 1), {16'd0, ir}, {16'd0, tbl[i].ir});
      chk($sformatf("alu_c%0d", i + 1), {24'd0, alu_out}, {24'd0, tbl[i].alu});
      chk($sformatf("zero_c%0d", i + 1), {31'd0, alu_zero}, {31'd0, tbl[i].zero});
      chk($sformatf("halted_c%0d", i + 1), {31'd0, halted}, {31'd0, tbl[i].halted});
    end
    chk_reg("run_R0", 0, 2'd0, 8'h05);
    chk_reg("run_R1", 0, 2'd1, 8'h03);
    chk_reg("run_R2", 0, 2'd2, 8'h08);
    chk_reg("run_R3", 0, 2'd3, 8'h02);

    // Sixteen more cycles: halt holds, or the wrapped second pass reproduces the registers
    step(16);
`ifdef TINY_PROC_PC_WRAP_EN
    chk("pass2_pc", {30'd0, pc}, 32'd0);
    chk("pass2_halted", {31'd0, halted}, 32'd0);
`else
    chk("pass2_pc", {30'd0, pc}, 32'd3);
    chk("pass2_halted", {31'd0, halted}, 32'd1);
`endif
    chk("pass2_ir", {16'd0, ir}, 32'h1301);
    chk_reg("pass2_R0", 0, 2'd0, 8'h05);
    chk_reg("pass2_R1", 0, 2'd1, 8'h03);
    chk_reg("pass2_R2", 0, 2'd2, 8'h08);
    chk_reg("pass2_R3", 0, 2'd3, 8'h02);

    // Stall for 5 cycles while EXECUTE of the ADD is pending
    do_reset();
    step(10);
    en = 1'b0;
    step(5);
    chk("stall_pc", {30'd0, pc}, 32'd2);
    chk("stall_ir", {16'd0, ir}, 32'h0201);
    chk("stall_alu", {24'd0, alu_out}, 32'h00);
    chk_reg("stall_R0", 0, 2'd0, 8'h05);
    chk_reg("stall_R2", 0, 2'd2, 8'h00);
    en = 1'b1;
    step(1);
    chk("stall_resume_alu", {24'd0, alu_out}, 32'h08);
    step(5);
    chk_reg("stall_R2_final", 0, 2'd2, 8'h08);
    chk_reg("stall_R3_final", 0, 2'd3, 8'h02);

    // Reset asserted during WRITEBACK of the ADD
    do_reset();
    step(11);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", {30'd0, pc}, 32'd0);
    chk("midrst_ir", {16'd0, ir}, 32'd0);
    chk("midrst_alu", {24'd0, alu_out}, 32'd0);
    chk_reg("midrst_R2", 0, 2'd2, 8'h00);
    chk_reg("midrst_R0", 0, 2'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
    chk("restart_pc", {30'd0, pc}, 32'd1);
    chk_reg("restart_R0", 0, 2'd0, 8'h05);
    chk_reg("restart_R2", 0, 2'd2, 8'h00);

    // Arithmetic wrap: 3-5 and FF+01
    do_reset();
    step(11);
    chk("zr_alu", {24'd0, zr_alu_out}, 32'h00);
    chk("zr_zero", {31'd0, zr_alu_zero}, 32'd1);
    chk("uf_alu", {24'd0, uf_alu_out}, 32'hFE);
    chk("uf_zero", {31'd0, uf_alu_zero}, 32'd0);
    step(5);
    chk_reg("uf_R0", 1, 2'd0, 8'h03);
    chk_reg("uf_R1", 1, 2'd1, 8'h05);
    chk_reg("uf_R2", 1, 2'd2, 8'hFE);
    chk_reg("uf_R3", 1, 2'd3, 8'h00);
    chk_reg("zr_R2", 2, 2'd2, 8'h00);
    chk_reg("zr_R3", 2, 2'd3, 8'hFE);
    chk("zr_alu_shl", {24'd0, zr_alu_out}, 32'hFE);
    chk("zr_zero_shl", {31'd0, zr_alu_zero}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
